lagarto_mc_rst_seq: RTL and testbench
=====================================

Name: lagarto_mc_rst_seq

Overview:
- Parametrised multi-hart reset/boot sequencer for Lagarto tiles; successor to the single-core wake-up counter plus reset synchronizer.
- Holds all harts in reset for a programmable wake-up interval, then releases them one at a time at a fixed stagger.
- Supports per-hart soft reset at runtime.
- Drives per-hart synchronized resets and the boot address / hart ID for each core.

Parameters:
NUM_HARTS, 4, number of cores sequenced (1..16)
WAKE_CYCLES, 32768, cycles from reset_l deassertion to first hart release (>=1)
STAGGER_CYCLES, 16, cycles between consecutive hart releases (0 = release all together)
SOFT_RST_CYCLES, 8, soft-reset hold length per hart (>=1)
SYNC_STAGES, 2, reset deassertion synchronizer depth (>=2)
BOOT_STRIDE, 64'h0, per-hart boot address increment

Ports:
clk_i  in  1  core clock
reset_l  in  1  global reset, asynchronous, active-low
boot_addr_i  in  64  base boot address
hart_id_base_i  in  64  hart ID of hart 0
soft_rst_req_i  in  NUM_HARTS  per-hart soft reset request, level-sampled
spc_grst_l_o  out  NUM_HARTS  per-hart synchronized reset, active-low
boot_addr_o  out  64*NUM_HARTS  per-hart boot address
hart_id_o  out  64*NUM_HARTS  per-hart hart ID
soft_rst_busy_o  out  NUM_HARTS  hart i is in a soft-reset hold
all_up_o  out  1  all harts out of reset and sequencer in RUN
state_o  out  2  FSM state: 0 WAKE, 1 STAGGER, 2 RUN

Behaviour:
- Reset: reset_l is asynchronous, active-low, on clock clk_i. It clears FSM to WAKE, all counters to 0, raw_rst_n[i]=0 and the synchronizer flops. Reset values: spc_grst_l_o=0, soft_rst_busy_o=0, all_up_o=0, state_o=0, boot_addr_o/hart_id_o=0.
- Reset mid-operation: reset_l low asserts every output to its reset value immediately, whatever the state.
- WAKE:
  - wake_cnt increments every edge.
  - On the edge where wake_cnt==WAKE_CYCLES-1: go to STAGGER, raw_rst_n[0]=1, idx=1, stag_cnt=0.
  - When STAGGER_CYCLES=0, all raw_rst_n go to 1 on that edge and the FSM goes straight to RUN.
- STAGGER:
  - stag_cnt increments every edge.
  - When stag_cnt==STAGGER_CYCLES-1: raw_rst_n[idx]=1, idx++, stag_cnt=0.
  - After releasing hart NUM_HARTS-1, go to RUN.
  - NUM_HARTS=1: go WAKE -> RUN directly.
  - Summary: raw_rst_n[i] rises after WAKE_CYCLES + i*STAGGER_CYCLES edges.
- Synchronizer, per hart:
  - Each hart has a SYNC_STAGES flop chain, clocked by clk_i and asynchronously cleared by (~reset_l | ~raw_rst_n[i]).
  - Assertion is immediate (raw_rst_n is itself a flop, so there is no glitch).
  - Deassertion reaches spc_grst_l_o[i] SYNC_STAGES edges after raw_rst_n[i] rises.
- RUN and soft reset:
  - In RUN, soft_rst_req_i[i]=1 at an edge sets raw_rst_n[i]=0, soft_rst_busy_o[i]=1 and loads sr_cnt[i]=SOFT_RST_CYCLES-1.
  - sr_cnt[i] decrements each edge. On the edge where sr_cnt[i]==0: raw_rst_n[i]=1, soft_rst_busy_o[i]=0.
  - A request while busy reloads sr_cnt[i] (extends the hold).
  - Harts are independent; simultaneous requests on several harts are all honoured.
  - Requests in WAKE/STAGGER are ignored, including for harts already released.
- boot_addr_o[i] = boot_addr_i + i*BOOT_STRIDE (64-bit, wraps modulo 2^64).
- hart_id_o[i] = hart_id_base_i + i.
- boot_addr_o[i] and hart_id_o[i] are registered: reloaded every edge while raw_rst_n[i]==0, frozen while the hart runs.
- all_up_o = (state==RUN) & (&spc_grst_l_o). It drops immediately when any hart enters soft reset.

Test Plan:
- Boot stagger (NUM_HARTS=4, WAKE=8, STAGGER=4, SYNC=2), reset_l released before edge 1 -> spc_grst_l_o bits rise after edges 10/14/18/22; state_o=2 from edge 20; all_up_o=1 from edge 22.
- STAGGER_CYCLES=0, WAKE=8 -> all four spc_grst_l_o rise together after edge 10; state_o goes 0->2 with no STAGGER.
- Soft reset hart 2 (SOFT_RST=8): one-cycle request in RUN at edge e -> spc_grst_l_o[2]=0 and all_up_o=0 after e; soft_rst_busy_o[2] falls at edge e+8; spc_grst_l_o[2] rises at e+10; other harts unaffected.
- Re-request at e+5 during the hold -> release moves to edge e+13 (busy) / e+15 (reset out).
- Frozen boot/ID values: boot_addr_i=0x8000_0000, stride 0x1000, hart_id_base=4 -> hart 3 sees 0x8000_3000 / ID 7. Change boot_addr_i in RUN -> outputs unchanged. Soft-reset hart 3 -> its boot address reloads.
- Reset mid-sequence: reset_l low during STAGGER with 2 harts up -> all outputs 0 asynchronously; re-release repeats the full WAKE sequence.
- Request during WAKE -> ignored; no busy flag, timing identical to the boot-stagger scenario.

Source files
------------

// File: rtl/lagarto_mc_rst_seq.sv
// ---------------------------------------------------------------------------
// lagarto_mc_rst_seq
//
// Multi-hart reset/boot sequencer for a Lagarto tile. After the global reset
// is released, every hart is held in reset for WAKE_CYCLES. The harts are then
// released one at a time, STAGGER_CYCLES apart. With STAGGER_CYCLES = 0 they
// are all released together. Once the sequencer reaches RUN, each hart can be
// put into a soft reset of SOFT_RST_CYCLES on its own. Every hart's reset is
// asserted immediately and deasserted through a SYNC_STAGES synchronizer. The
// boot address and hart ID for a hart are captured while that hart is in
// reset, and they hold their value while the hart runs.
//
// Ports:
//   clk_i            core clock
//   reset_l          global reset, asynchronous, active-low
//   boot_addr_i      base boot address (hart 0)
//   hart_id_base_i   hart ID of hart 0
//   soft_rst_req_i   per-hart soft reset request, sampled on every edge in RUN
//   spc_grst_l_o     per-hart synchronized reset, active-low
//   boot_addr_o      per-hart boot address, hart i in bits [64*i +: 64]
//   hart_id_o        per-hart hart ID, hart i in bits [64*i +: 64]
//   soft_rst_busy_o  hart i is in a soft-reset hold
//   all_up_o         every hart is out of reset and the sequencer is in RUN
//   state_o          sequencer state: 0 WAKE, 1 STAGGER, 2 RUN
// ---------------------------------------------------------------------------
module lagarto_mc_rst_seq #(
   parameter int unsigned NUM_HARTS       = 4,
   parameter int unsigned WAKE_CYCLES     = 32768,
   parameter int unsigned STAGGER_CYCLES  = 16,
   parameter int unsigned SOFT_RST_CYCLES = 8,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter logic [63:0] BOOT_STRIDE     = 64'h0
) (
   input  logic                     clk_i,
   input  logic                     reset_l,
   input  logic [63:0]              boot_addr_i,
   input  logic [63:0]              hart_id_base_i,
   input  logic [NUM_HARTS-1:0]     soft_rst_req_i,
   output logic [NUM_HARTS-1:0]     spc_grst_l_o,
   output logic [64*NUM_HARTS-1:0]  boot_addr_o,
   output logic [64*NUM_HARTS-1:0]  hart_id_o,
   output logic [NUM_HARTS-1:0]     soft_rst_busy_o,
   output logic                     all_up_o,
   output logic [1:0]               state_o
);

   // Every counter is at least one bit wide, so degenerate parameter values
   // such as WAKE_CYCLES = 1 or STAGGER_CYCLES = 0 do not produce
   // zero-width vectors.
   localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam int unsigned STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam int unsigned SR_W   = (SOFT_RST_CYCLES > 1) ? $clog2(SOFT_RST_CYCLES) : 1;
   localparam int unsigned IDX_W  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
   localparam logic [STAG_W-1:0] STAG_LAST =
      STAG_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
   localparam logic [SR_W-1:0]   SR_LOAD   = SR_W'(SOFT_RST_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_HARTS - 1);

   // When there is nothing to stagger, the end of WAKE releases every hart
   // at once, and the sequencer goes straight to RUN.
   localparam bit DIRECT_RUN = (STAGGER_CYCLES == 0) || (NUM_HARTS == 1);

   typedef enum logic [1:0] {
      ST_WAKE    = 2'd0,
      ST_STAGGER = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [WAKE_W-1:0]     wake_cnt_q;
   logic [STAG_W-1:0]     stag_cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  wake_done;
   logic                  stag_step;
   logic                  last_step;

   logic [NUM_HARTS-1:0]  raw_rst_n_q;
   logic [NUM_HARTS-1:0]  raw_rst_n_d;
   logic [NUM_HARTS-1:0]  busy_q;
   logic [NUM_HARTS-1:0]  busy_d;
   logic [SR_W-1:0]       sr_cnt_q [NUM_HARTS];
   logic [SR_W-1:0]       sr_cnt_d [NUM_HARTS];
   logic [63:0]           boot_q   [NUM_HARTS];
   logic [63:0]           hid_q    [NUM_HARTS];

   // Sequencer state register. A low reset_l returns the sequencer to WAKE
   // from any state. Releasing reset_l therefore always replays the full
   // wake-up and stagger sequence.
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         state_q <= ST_WAKE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. wake_done marks the edge that releases hart 0.
   // stag_step marks each later release, and last_step marks the release of
   // the final hart, which ends the stagger phase.
   always_comb begin
      state_d   = state_q;
      wake_done = 1'b0;
      stag_step = 1'b0;
      last_step = 1'b0;
      case (state_q)
         ST_WAKE: begin
            wake_done = (wake_cnt_q == WAKE_LAST);
            if (wake_done) begin
               state_d = DIRECT_RUN ? ST_RUN : ST_STAGGER;
            end
         end
         ST_STAGGER: begin
            stag_step = (stag_cnt_q == STAG_LAST);
            last_step = stag_step && (idx_q == IDX_LAST);
            if (last_step) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_WAKE;
         end
      endcase
   end

   // Wake and stagger counters, plus the index of the next hart to release.
   // After the wake interval, hart 0 is already out of reset, so the index
   // restarts at 1. The stagger counter restarts after every release.
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         wake_cnt_q <= '0;
         stag_cnt_q <= '0;
         idx_q      <= '0;
      end else begin
         if (state_q == ST_WAKE) begin
            wake_cnt_q <= wake_cnt_q + WAKE_W'(1);
         end
         if (wake_done) begin
            idx_q      <= IDX_W'(1);
            stag_cnt_q <= '0;
         end else if (state_q == ST_STAGGER) begin
            if (stag_step) begin
               stag_cnt_q <= '0;
               idx_q      <= idx_q + IDX_W'(1);
            end else begin
               stag_cnt_q <= stag_cnt_q + STAG_W'(1);
            end
         end
      end
   end

   // Per-hart raw reset and soft-reset hold. A hart leaves its boot reset
   // either at the end of WAKE or at its stagger slot. Soft-reset requests
   // take effect only in RUN. A new request while a hold is running reloads
   // the counter, which extends the hold. The raw reset is released on the
   // edge where the counter reads zero.
   always_comb begin
      raw_rst_n_d = raw_rst_n_q;
      busy_d      = busy_q;
      sr_cnt_d    = sr_cnt_q;
      for (int i = 0; i < NUM_HARTS; i++) begin
         if (wake_done && ((i == 0) || (STAGGER_CYCLES == 0))) begin
            raw_rst_n_d[i] = 1'b1;
         end
         if (stag_step && (idx_q == IDX_W'(i))) begin
            raw_rst_n_d[i] = 1'b1;
         end
         if (state_q == ST_RUN) begin
            if (soft_rst_req_i[i]) begin
               raw_rst_n_d[i] = 1'b0;
               busy_d[i]      = 1'b1;
               sr_cnt_d[i]    = SR_LOAD;
            end else if (busy_q[i]) begin
               if (sr_cnt_q[i] == '0) begin
                  raw_rst_n_d[i] = 1'b1;
                  busy_d[i]      = 1'b0;
               end else begin
                  sr_cnt_d[i] = sr_cnt_q[i] - SR_W'(1);
               end
            end
         end
      end
   end

   // Per-hart registers. The boot address and hart ID reload on every edge
   // while the hart's raw reset is held. A hart therefore starts with the
   // values that were present just before its release. Those values then
   // stay frozen until the hart is reset again.
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         raw_rst_n_q <= '0;
         busy_q      <= '0;
         for (int i = 0; i < NUM_HARTS; i++) begin
            sr_cnt_q[i] <= '0;
            boot_q[i]   <= '0;
            hid_q[i]    <= '0;
         end
      end else begin
         raw_rst_n_q <= raw_rst_n_d;
         busy_q      <= busy_d;
         for (int i = 0; i < NUM_HARTS; i++) begin
            sr_cnt_q[i] <= sr_cnt_d[i];
            if (!raw_rst_n_q[i]) begin
               boot_q[i] <= boot_addr_i + (BOOT_STRIDE * 64'(i));
               hid_q[i]  <= hart_id_base_i + 64'(i);
            end
         end
      end
   end

   // Reset synchronizer for each hart. raw_rst_n is driven by a flop, so the
   // combined clear is glitch-free, and reset assertion reaches the hart
   // immediately. Deassertion ripples through SYNC_STAGES flops before the
   // hart sees it.
   for (genvar g = 0; g < NUM_HARTS; g++) begin : g_hart
      logic                   hart_rst_n;
      logic [SYNC_STAGES-1:0] sync_q;

      assign hart_rst_n = reset_l & raw_rst_n_q[g];

      always_ff @(posedge clk_i or negedge hart_rst_n) begin
         if (!hart_rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
         end
      end

      assign spc_grst_l_o[g]           = sync_q[SYNC_STAGES-1];
      assign boot_addr_o[g*64 +: 64]   = boot_q[g];
      assign hart_id_o[g*64 +: 64]     = hid_q[g];
   end

   assign soft_rst_busy_o = busy_q;
   assign state_o         = state_q;
   assign all_up_o        = (state_q == ST_RUN) && (&spc_grst_l_o);

endmodule

// File: tb/tb_lagarto_mc_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_lagarto_mc_rst_seq
//
// Drives two sequencers from the same stimulus. One is staggered
// (WAKE=8, STAGGER=4) and the other releases all harts together (STAGGER=0).
// For every clock edge, and for every asynchronous reset assertion, the
// stimulus side pushes the expected outputs into a queue. The expected values
// come from a closed-form model: release edges, soft-reset end edges, and
// capture rules. A separate monitor pops each entry and compares it against
// both instances.
// ---------------------------------------------------------------------------
module tb_lagarto_mc_rst_seq;

   localparam int          NH     = 4;
   localparam int          WAKE   = 8;
   localparam int          STAG_A = 4;
   localparam int          SOFT   = 8;
   localparam int          SYNC   = 2;
   localparam logic [63:0] STRIDE = 64'h1000;

   logic                 clk_i = 1'b0;
   logic                 reset_l;
   logic [63:0]          boot_addr_i;
   logic [63:0]          hart_id_base_i;
   logic [NH-1:0]        soft_rst_req_i;

   logic [NH-1:0]        spc_a, spc_b, busy_a, busy_b;
   logic [64*NH-1:0]     boot_a, boot_b, hid_a, hid_b;
   logic                 up_a, up_b;
   logic [1:0]           st_a, st_b;

   typedef struct packed {
      logic [1:0][NH-1:0]        spc;
      logic [1:0][NH-1:0]        busy;
      logic [1:0]                up;
      logic [1:0][1:0]           st;
      logic [1:0][NH-1:0][63:0]  boot;
      logic [1:0][NH-1:0][63:0]  hid;
   } obs_t;

   obs_t        exp_q [$];
   int          n_total = 0;
   int          n_bad   = 0;

   int          mt;
   int          sr_end   [2][NH];
   logic [63:0] cap_boot [2][NH];
   logic [63:0] cap_hid  [2][NH];

   always #5 clk_i = ~clk_i;

   lagarto_mc_rst_seq #(
      .NUM_HARTS(NH), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(STAG_A),
      .SOFT_RST_CYCLES(SOFT), .SYNC_STAGES(SYNC), .BOOT_STRIDE(STRIDE)
   ) dut_stag (
      .clk_i(clk_i), .reset_l(reset_l), .boot_addr_i(boot_addr_i),
      .hart_id_base_i(hart_id_base_i), .soft_rst_req_i(soft_rst_req_i),
      .spc_grst_l_o(spc_a), .boot_addr_o(boot_a), .hart_id_o(hid_a),
      .soft_rst_busy_o(busy_a), .all_up_o(up_a), .state_o(st_a)
   );

   lagarto_mc_rst_seq #(
      .NUM_HARTS(NH), .WAKE_CYCLES(WAKE), .STAGGER_CYCLES(0),
      .SOFT_RST_CYCLES(SOFT), .SYNC_STAGES(SYNC), .BOOT_STRIDE(STRIDE)
   ) dut_flat (
      .clk_i(clk_i), .reset_l(reset_l), .boot_addr_i(boot_addr_i),
      .hart_id_base_i(hart_id_base_i), .soft_rst_req_i(soft_rst_req_i),
      .spc_grst_l_o(spc_b), .boot_addr_o(boot_b), .hart_id_o(hid_b),
      .soft_rst_busy_o(busy_b), .all_up_o(up_b), .state_o(st_b)
   );

   // Reference model: sequencer state as a function of edges since release.
   function automatic int stagOf(input int k);
      return (k == 0) ? STAG_A : 0;
   endfunction

   function automatic int mState(input int k, input int tt);
      if (tt < WAKE) return 0;
      if (stagOf(k) == 0) return 2;
      if (tt < WAKE + (NH - 1) * stagOf(k)) return 1;
      return 2;
   endfunction

   function automatic int relEdge(input int k, input int i);
      return WAKE + i * stagOf(k);
   endfunction

   function automatic bit mRaw(input int k, input int i, input int tt);
      return (tt >= relEdge(k, i)) && (tt >= sr_end[k][i]);
   endfunction

   function automatic bit mSpc(input int k, input int i, input int tt);
      int r;
      r = (relEdge(k, i) > sr_end[k][i]) ? relEdge(k, i) : sr_end[k][i];
      return tt >= r + SYNC;
   endfunction

   function automatic obs_t modelOut();
      obs_t o;
      o = '0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NH; i++) begin
            o.spc[k][i]  = mSpc(k, i, mt);
            o.busy[k][i] = (mt < sr_end[k][i]);
            o.boot[k][i] = cap_boot[k][i];
            o.hid[k][i]  = cap_hid[k][i];
         end
         o.st[k] = 2'(mState(k, mt));
         o.up[k] = (mState(k, mt) == 2) && (&o.spc[k]);
      end
      return o;
   endfunction

   task automatic modelReset();
      mt = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NH; i++) begin
            sr_end[k][i]   = 0;
            cap_boot[k][i] = '0;
            cap_hid[k][i]  = '0;
         end
      end
   endtask

   task automatic modelEdge(input logic [NH-1:0] req, input logic [63:0] boot,
                            input logic [63:0] hid);
      int tp;
      tp = mt;
      mt = mt + 1;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < NH; i++) begin
            if (!mRaw(k, i, tp)) begin
               cap_boot[k][i] = boot + STRIDE * 64'(i);
               cap_hid[k][i]  = hid + 64'(i);
            end
            if (req[i] && (mState(k, tp) == 2)) begin
               sr_end[k][i] = mt + SOFT;
            end
         end
      end
   endtask

   task automatic cmpField(input string name, input logic [63:0] act,
                           input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
      end
   endtask

   task automatic checkOutput(input obs_t e);
      obs_t a;
      a.spc[0]  = spc_a;  a.spc[1]  = spc_b;
      a.busy[0] = busy_a; a.busy[1] = busy_b;
      a.up[0]   = up_a;   a.up[1]   = up_b;
      a.st[0]   = st_a;   a.st[1]   = st_b;
      a.boot[0] = boot_a; a.boot[1] = boot_b;
      a.hid[0]  = hid_a;  a.hid[1]  = hid_b;
      for (int k = 0; k < 2; k++) begin
         cmpField($sformatf("dut%0d.spc_grst_l", k), 64'(a.spc[k]), 64'(e.spc[k]));
         cmpField($sformatf("dut%0d.busy", k), 64'(a.busy[k]), 64'(e.busy[k]));
         cmpField($sformatf("dut%0d.all_up", k), 64'(a.up[k]), 64'(e.up[k]));
         cmpField($sformatf("dut%0d.state", k), 64'(a.st[k]), 64'(e.st[k]));
         for (int i = 0; i < NH; i++) begin
            cmpField($sformatf("dut%0d.boot%0d", k, i), a.boot[k][i], e.boot[k][i]);
            cmpField($sformatf("dut%0d.hid%0d", k, i), a.hid[k][i], e.hid[k][i]);
         end
      end
   endtask

   // Each call covers one clock edge. Inputs change on the falling edge, and
   // the model advances to predict the following rising edge. A falling
   // reset_l also queues an immediate all-zero expectation, which the
   // monitor checks right after the asynchronous assertion.
   task automatic applyStimulus(input logic rst_l, input logic [NH-1:0] req,
                                input logic [63:0] boot, input logic [63:0] hid);
      @(negedge clk_i);
      if (!rst_l && (reset_l === 1'b1)) begin
         modelReset();
         exp_q.push_back(modelOut());
      end
      soft_rst_req_i = req;
      boot_addr_i    = boot;
      hart_id_base_i = hid;
      reset_l        = rst_l;
      if (rst_l) modelEdge(req, boot, hid);
      else       modelReset();
      exp_q.push_back(modelOut());
   endtask

   // Monitor: compares one queued expectation after every rising clock edge
   // and after every asynchronous reset assertion.
   initial begin
      forever begin
         @(posedge clk_i or negedge reset_l);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] rb;
      logic [NH-1:0] rq;
      reset_l        = 1'b0;
      soft_rst_req_i = '0;
      boot_addr_i    = 64'h8000_0000;
      hart_id_base_i = 64'd4;
      modelReset();

      $display("[TB] reset and boot stagger");
      repeat (3) applyStimulus(1'b0, 4'($urandom), 64'h8000_0000, 64'd4);
      for (int c = 0; c < 30; c++) begin
         rq = (c < 19) ? NH'($urandom) : '0;
         applyStimulus(1'b1, rq, 64'h8000_0000, 64'd4);
      end
      @(posedge clk_i);
      #2;
      cmpField("hart3 boot after boot", boot_a[3*64 +: 64], 64'h8000_3000);
      cmpField("hart3 id after boot", hid_a[3*64 +: 64], 64'd7);
      cmpField("all_up after boot", 64'(up_a), 64'd1);

      $display("[TB] boot values frozen in RUN");
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, '0, {$urandom, $urandom}, {$urandom, $urandom});
      end

      $display("[TB] soft reset hart 2, then extended hold");
      applyStimulus(1'b1, 4'b0100, 64'h8000_0000, 64'd4);
      repeat (12) applyStimulus(1'b1, '0, 64'h8000_0000, 64'd4);
      applyStimulus(1'b1, 4'b0100, 64'h8000_0000, 64'd4);
      repeat (4) applyStimulus(1'b1, '0, 64'h8000_0000, 64'd4);
      applyStimulus(1'b1, 4'b0100, 64'h8000_0000, 64'd4);
      repeat (16) applyStimulus(1'b1, '0, 64'h8000_0000, 64'd4);

      $display("[TB] soft reset hart 3 reloads boot values");
      applyStimulus(1'b1, 4'b1000, 64'hA000_0000, 64'd9);
      repeat (12) applyStimulus(1'b1, '0, 64'hA000_0000, 64'd9);
      @(posedge clk_i);
      #2;
      cmpField("hart3 boot after soft reset", boot_a[3*64 +: 64], 64'hA000_3000);
      cmpField("hart3 id after soft reset", hid_a[3*64 +: 64], 64'd12);
      cmpField("hart0 boot still frozen", boot_a[0 +: 64], 64'h8000_0000);

      $display("[TB] random soft resets and inputs");
      for (int c = 0; c < 200; c++) begin
         for (int i = 0; i < NH; i++) rq[i] = ($urandom_range(15) == 0);
         rb = {$urandom, $urandom};
         applyStimulus(1'b1, rq, rb, {$urandom, $urandom});
      end

      $display("[TB] reset during stagger");
      repeat (2) applyStimulus(1'b0, '0, 64'h4000_0000, 64'd0);
      repeat (15) applyStimulus(1'b1, '0, 64'h4000_0000, 64'd0);
      repeat (3) applyStimulus(1'b0, '0, 64'h4000_0000, 64'd0);
      repeat (40) applyStimulus(1'b1, '0, 64'h5000_0000, 64'd32);

      @(posedge clk_i);
      #3;
      cmpField("expectation queue drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
